// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC generation, single-outstanding imem handshake, IF/ID output register.
// Optional misaligned-redirect exception enabled by defining FETCH_MISALIGN_CHK_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_cs,
  output logic [31:0] inst_encoding,
  output logic [31:0] pc,
  output logic        inst_valid,
  output logic        fetch_exc
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [31:0] buf_enc;
  logic [31:0] buf_pc;
  logic        exc_q;
  logic [31:0] redir_tgt;
  logic        redir_misalign;
  logic        outstanding;
  logic        ld_mem;
  logic        ld_buf;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_tgt      = redirect_pc;
  assign redir_misalign = |redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_q <= 1'b0;
    end else if (redirect_valid) begin
      exc_q <= redir_misalign;
    end
  end
`else
  assign redir_tgt      = {redirect_pc[31:2], 2'b00};
  assign redir_misalign = 1'b0;
  assign exc_q          = 1'b0;
`endif

  // A response is still owed by memory if we hold a grant without its data yet
  assign outstanding = ((state == S_FETCH) && imem_gnt) ||
                       (((state == S_WAIT) || (state == S_DRAIN)) && !imem_rvalid);

  assign ld_mem = (state == S_WAIT) && imem_rvalid && !stall_cs;
  assign ld_buf = (state == S_HOLD) && !stall_cs;

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = fetch_pc;
  assign fetch_exc = exc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      fetch_pc      <= RESET_PC;
      inst_encoding <= NOP_INST;
      pc            <= 32'h0;
      inst_valid    <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc      <= redir_tgt;
      inst_encoding <= NOP_INST;
      if (redir_misalign) begin
        pc         <= redirect_pc;
        inst_valid <= 1'b1;
        state      <= outstanding ? S_DRAIN : S_IDLE;
      end else begin
        inst_valid <= 1'b0;
        state      <= outstanding ? S_DRAIN : S_FETCH;
      end
    end else begin
      case (state)
        S_IDLE:  if (!exc_q) state <= S_FETCH;
        S_FETCH: if (imem_gnt) state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (!stall_cs) begin
              fetch_pc <= req_pc + 32'd4;
              state    <= S_FETCH;
            end else begin
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_cs) begin
            fetch_pc <= buf_pc + 32'd4;
            state    <= S_FETCH;
          end
        end
        S_DRAIN: if (imem_rvalid) state <= exc_q ? S_IDLE : S_FETCH;
        default: state <= S_IDLE;
      endcase

      // IF/ID register advances only when decode is not stalled
      if (!stall_cs) begin
        if (ld_mem) begin
          inst_encoding <= imem_rdata;
          pc            <= req_pc;
          inst_valid    <= 1'b1;
        end else if (ld_buf) begin
          inst_encoding <= buf_enc;
          pc            <= buf_pc;
          inst_valid    <= 1'b1;
        end else begin
          inst_encoding <= NOP_INST;
          inst_valid    <= 1'b0;
        end
      end
    end
  end

  // Request address and parked response carry no control meaning, so no reset
  always_ff @(posedge clk) begin
    if ((state == S_FETCH) && imem_gnt) begin
      req_pc <= fetch_pc;
    end
    if ((state == S_WAIT) && imem_rvalid && stall_cs && !redirect_valid) begin
      buf_enc <= imem_rdata;
      buf_pc  <= req_pc;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: drives the imem handshake by hand, cycle by cycle.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_cs;
  logic [31:0] inst_encoding;
  logic [31:0] pc;
  logic        inst_valid;
  logic        fetch_exc;

  int n_vec;
  int n_err;

  if_fetch_unit #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_cs       (stall_cs),
    .inst_encoding  (inst_encoding),
    .pc             (pc),
    .inst_valid     (inst_valid),
    .fetch_exc      (fetch_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant at the current FETCH, return data one cycle later
  task automatic xfer(input logic [31:0] d);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    tick();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    stall_cs = 1'b0;
    tick();
    tick();
    chk_val("rst_req",   {31'h0, imem_req},   32'h0);
    chk_val("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk_val("rst_enc",   inst_encoding,       NOP);
    chk_val("rst_pc",    pc,                  32'h0);
    chk_val("rst_exc",   {31'h0, fetch_exc},  32'h0);

    rst_n = 1'b1;
    tick();
    chk_val("t1_req0",  {31'h0, imem_req}, 32'h1);
    chk_val("t1_addr0", imem_addr,         32'h0);

    // 1: back-to-back fetches, two-cycle latency from grant
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk_val("t1_wait_req", {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    chk_val("t1_valid0", {31'h0, inst_valid}, 32'h1);
    chk_val("t1_pc0",    pc,                  32'h0);
    chk_val("t1_enc0",   inst_encoding,       32'h0050_0093);
    chk_val("t1_addr4",  imem_addr,           32'h4);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk_val("t1_bubble_v",  {31'h0, inst_valid}, 32'h0);
    chk_val("t1_bubble_e",  inst_encoding,       NOP);
    chk_val("t1_bubble_pc", pc,                  32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0010_0113;
    tick();
    imem_rvalid = 1'b0;
    chk_val("t1_pc4",   pc,        32'h4);
    chk_val("t1_enc4",  inst_encoding, 32'h0010_0113);
    chk_val("t1_addr8", imem_addr, 32'h8);

    // 2: response arrives under stall, parked until the stall drops
    stall_cs = 1'b1;
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0113;
    tick();
    imem_rvalid = 1'b0;
    chk_val("t2_hold_pc",  pc,                  32'h4);
    chk_val("t2_hold_v",   {31'h0, inst_valid}, 32'h1);
    chk_val("t2_hold_req", {31'h0, imem_req},   32'h0);
    tick();
    chk_val("t2_hold_req2", {31'h0, imem_req}, 32'h0);
    chk_val("t2_hold_enc",  inst_encoding,     32'h0010_0113);
    stall_cs = 1'b0;
    tick();
    chk_val("t2_pc8",   pc,            32'h8);
    chk_val("t2_enc8",  inst_encoding, 32'h00A0_0113);
    chk_val("t2_v8",    {31'h0, inst_valid}, 32'h1);
    chk_val("t2_addrC", imem_addr,     32'hC);
    chk_val("t2_req",   {31'h0, imem_req}, 32'h1);

    // 3: redirect while waiting, late response must be discarded
    xfer(32'h0000_0033);
    chk_val("t3_pcC",    pc,        32'hC);
    chk_val("t3_addr10", imem_addr, 32'h10);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk_val("t3_drain_req", {31'h0, imem_req},   32'h0);
    chk_val("t3_drain_v",   {31'h0, inst_valid}, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk_val("t3_v",    {31'h0, inst_valid}, 32'h0);
    chk_val("t3_enc",  inst_encoding,       NOP);
    chk_val("t3_pc",   pc,                  32'hC);
    chk_val("t3_req",  {31'h0, imem_req},   32'h1);
    chk_val("t3_addr", imem_addr,           32'h100);

    // 4: redirect with same-cycle rvalid under stall drops the response
    xfer(32'h0020_0193);
    chk_val("t4_pc100", pc, 32'h100);
    stall_cs = 1'b1;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk_val("t4_held_v", {31'h0, inst_valid}, 32'h1);
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h1234_5678;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    stall_cs       = 1'b0;
    chk_val("t4_v",    {31'h0, inst_valid}, 32'h0);
    chk_val("t4_enc",  inst_encoding,       NOP);
    chk_val("t4_req",  {31'h0, imem_req},   32'h1);
    chk_val("t4_addr", imem_addr,           32'h40);

    // 5: PC wraps modulo 2^32
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk_val("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    xfer(32'h0030_0193);
    chk_val("t5_pc_top", pc,        32'hFFFF_FFFC);
    chk_val("t5_wrap",   imem_addr, 32'h0);

    // Redirect coinciding with a grant owes a response, so it drains first
    imem_gnt       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b0;
    chk_val("gd_req", {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0000;
    tick();
    imem_rvalid = 1'b0;
    chk_val("gd_req2", {31'h0, imem_req},   32'h1);
    chk_val("gd_addr", imem_addr,           32'h80);
    chk_val("gd_v",    {31'h0, inst_valid}, 32'h0);

    // 6: misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    chk_val("t6_exc",  {31'h0, fetch_exc},  32'h1);
    chk_val("t6_pc",   pc,                  32'h102);
    chk_val("t6_v",    {31'h0, inst_valid}, 32'h1);
    chk_val("t6_req",  {31'h0, imem_req},   32'h0);
    tick();
    tick();
    chk_val("t6_req_idle", {31'h0, imem_req},  32'h0);
    chk_val("t6_exc_held", {31'h0, fetch_exc}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk_val("t6_exc_clr", {31'h0, fetch_exc}, 32'h0);
    chk_val("t6_req2",    {31'h0, imem_req},  32'h1);
    chk_val("t6_addr2",   imem_addr,          32'h200);
`else
    chk_val("t6_exc0", {31'h0, fetch_exc}, 32'h0);
    chk_val("t6_req",  {31'h0, imem_req},  32'h1);
    chk_val("t6_addr", imem_addr,          32'h100);
`endif

    // Async reset in the middle of a transaction
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_val("ar_req", {31'h0, imem_req},   32'h0);
    chk_val("ar_v",   {31'h0, inst_valid}, 32'h0);
    chk_val("ar_pc",  pc,                  32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_val("ar_req2", {31'h0, imem_req}, 32'h1);
    chk_val("ar_addr", imem_addr,         32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
